// File: rtl/flounder_bus_pkg.sv
// Shared bus constants for the Flounder CPLD: the LCD sequencer state
// encoding and the I/O window bases (ADDR[15:13]). The address decoder
// imports the same window constants.
package flounder_bus_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP  = 3'd1;
    localparam state_t ST_STROBE = 3'd2;
    localparam state_t ST_HOLD   = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // I/O windows, compared against ADDR[15:13]
    localparam logic [2:0] LCD0_BASE = 3'b011;  // 0x6000
    localparam logic [2:0] LCD1_BASE = 3'b100;  // 0x8000

endpackage

// File: rtl/flounder_lcd_io_sequencer.sv
// Bus-cycle sequencer for the character-LCD I/O windows. An I/O read or
// write to 0x6000 (LCD0) or 0x8000 (LCD1) holds the Z180 in wait states
// while a setup / pulse / hold timed enable strobe is produced on LCD_E0
// or LCD_E1. One CPU I/O cycle yields exactly one strobe; releasing
// /IORQ early aborts the strobe.
//
// Handshake: the CPU "requests" by holding /IORQ low with /RD or /WR low
// in an LCD window; the block acknowledges by releasing /WAIT (high)
// once the hold time has elapsed, then waits in DONE for /IORQ to rise.
//
// DBG_STATE exposes the FSM state for status logic and checkers.
module flounder_lcd_io_sequencer
    import flounder_bus_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] ADDR,
    input  logic        IOREQ,
    input  logic        M1,
    input  logic        R,
    input  logic        W,
    output logic        WAIT,
    output logic        LCD_E0,
    output logic        LCD_E1,
    output logic        BUSY,
    output logic [2:0]  DBG_STATE
);

    localparam logic [CNT_W-1:0] SETUP_INIT = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_INIT  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

    // True when the top address bits fall in either LCD window
    function automatic logic lcd_window(input logic [2:0] a_hi);
        return (a_hi == LCD0_BASE) || (a_hi == LCD1_BASE);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ch_q, ch_d;
    logic             hit;

    // Only A15..A13 take part in the decode
    logic unused_addr;
    assign unused_addr = ^ADDR[12:0];

    // Qualified LCD I/O cycle; interrupt-ack (M1 low) never hits
    assign hit = ~IOREQ & M1 & (~R | ~W) & lcd_window(ADDR[15:13]);

    // State, timer and channel registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            ch_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ch_q    <= ch_d;
        end
    end

    // Next-state: timed phases, abort on /IORQ release, one strobe per cycle
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_SETUP;
                    timer_d = SETUP_INIT;
                    ch_d    = ADDR[15];
                end
            end
            ST_SETUP: begin
                if (IOREQ) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = ST_STROBE;
                    timer_d = PULSE_INIT;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            ST_STROBE: begin
                if (IOREQ) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = ST_HOLD;
                    timer_d = HOLD_INIT;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            ST_HOLD: begin
                if (IOREQ) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = ST_DONE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            ST_DONE: begin
                if (IOREQ) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs: E from registered state, /WAIT also from the live hit so it
    // falls in the same T-state as /IORQ; reset forces /WAIT high
    always_comb begin
        LCD_E0    = (state_q == ST_STROBE) & ~ch_q;
        LCD_E1    = (state_q == ST_STROBE) & ch_q;
        BUSY      = (state_q != ST_IDLE);
        DBG_STATE = state_q;
        WAIT      = ~(((state_q == ST_IDLE) & hit & RST) |
                      (state_q == ST_SETUP) |
                      (state_q == ST_STROBE) |
                      (state_q == ST_HOLD));
    end

endmodule

// File: tb/tb_flounder_lcd_io_sequencer.sv
// Testbench for flounder_lcd_io_sequencer: decode table, directed timing
// sequences, and randomized bus traffic against a cycle-count model.
module tb_flounder_lcd_io_sequencer;
    import flounder_bus_pkg::*;

    localparam int S     = 2;
    localparam int P     = 12;
    localparam int H     = 2;
    localparam int TOTAL = S + P + H;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] ADDR;
    logic        IOREQ, M1, R, W;
    logic        WAIT, LCD_E0, LCD_E1, BUSY;
    logic [2:0]  DBG_STATE;

    always #5 CLK = ~CLK;

    flounder_lcd_io_sequencer #(
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .CNT_W(4)
    ) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .IOREQ(IOREQ), .M1(M1),
        .R(R), .W(W), .WAIT(WAIT), .LCD_E0(LCD_E0), .LCD_E1(LCD_E1),
        .BUSY(BUSY), .DBG_STATE(DBG_STATE)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is "active" for TOTAL cycles after its start edge; E is
    // high while the elapsed count is within [S, S+P); afterwards the
    // sequencer is parked until /IORQ rises.
    function automatic bit ref_hit();
        return !IOREQ && M1 && (!R || !W) && ADDR >= 16'h6000 && ADDR < 16'hA000;
    endfunction

    int   m_el;
    bit   m_act, m_done, m_ch;
    logic [0:0] exp_q[$];

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_ch   <= 1'b0;
            m_el   <= 0;
            exp_q.delete();
        end else if (m_done) begin
            if (IOREQ) m_done <= 1'b0;
        end else if (m_act) begin
            if (IOREQ) begin
                m_act <= 1'b0;
            end else begin
                m_el <= m_el + 1;
                if (m_el + 1 == S) exp_q.push_back(m_ch);
                if (m_el + 1 == TOTAL) begin
                    m_act  <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end else if (ref_hit()) begin
            m_act <= 1'b1;
            m_el  <= 0;
            m_ch  <= (ADDR >= 16'h8000);
        end
    end

    // ---------------- continuous scoreboard ----------------
    bit mon_en = 1'b0;
    bit prev_e = 1'b0;

    always @(negedge CLK) begin
        #4;
        if (mon_en) begin
            bit exp_e, exp_wait;
            exp_e    = m_act && m_el >= S && m_el < S + P;
            exp_wait = !(m_act || (!m_act && !m_done && RST && ref_hit()));
            chk("mdl_e0",   LCD_E0, exp_e && !m_ch);
            chk("mdl_e1",   LCD_E1, exp_e && m_ch);
            chk("mdl_busy", BUSY,   m_act || m_done);
            chk("mdl_wait", WAIT,   exp_wait);
            if ((LCD_E0 || LCD_E1) && !prev_e) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_strobe", 1, 0);
                end else begin
                    logic [0:0] exp_ch;
                    exp_ch = exp_q.pop_front();
                    chk("sb_strobe_channel", LCD_E1, exp_ch);
                end
            end
            prev_e = LCD_E0 || LCD_E1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        IOREQ = 1'b1; M1 = 1'b1; R = 1'b1; W = 1'b1;
    endtask

    task automatic bus_io(input logic [15:0] a, input bit wr);
        ADDR = a; M1 = 1'b1; IOREQ = 1'b0;
        R = wr; W = !wr;
    endtask

    task automatic idle_cycles(input int n);
        bus_idle();
        repeat (n) @(negedge CLK);
    endtask

    // Per-run measurements; sample k is taken after posedge k
    int e0_cnt, e1_cnt, e0_first, e1_first, wait_rel, overlap;
    bit busy_last;

    task automatic run_cycles(input int n);
        e0_cnt = 0; e1_cnt = 0; e0_first = -1; e1_first = -1;
        wait_rel = -1; overlap = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK);
            if (LCD_E0) begin e0_cnt++; if (e0_first < 0) e0_first = k; end
            if (LCD_E1) begin e1_cnt++; if (e1_first < 0) e1_first = k; end
            if (LCD_E0 && LCD_E1) overlap++;
            if (WAIT && wait_rel < 0) wait_rel = k;
            busy_last = BUSY;
        end
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [15:0] addr;
        logic        ioreq, m1, r, w;
        logic        exp_wait;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{16'h6000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h9FFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'h5FFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{16'hA000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{16'h4000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{16'h6000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{16'h6000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{16'hE000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    end

    // ---------------- main sequence ----------------
    initial begin
        RST = 1'b0;
        ADDR = 16'h0000;
        bus_idle();

        // Reset: outputs quiet and /WAIT high even with a live hit
        #12;
        bus_io(16'h6000, 1'b1);
        #1;
        chk("rst_wait",  WAIT, 1);
        chk("rst_e0",    LCD_E0, 0);
        chk("rst_e1",    LCD_E1, 0);
        chk("rst_busy",  BUSY, 0);
        chk("rst_state", DBG_STATE, ST_IDLE);
        bus_idle();
        @(negedge CLK);
        RST = 1'b1;
        mon_en = 1'b1;
        idle_cycles(2);

        // Decode table: /WAIT in IDLE follows the window decode
        foreach (vecs[i]) begin
            ADDR = vecs[i].addr; IOREQ = vecs[i].ioreq; M1 = vecs[i].m1;
            R = vecs[i].r; W = vecs[i].w;
            #1;
            chk($sformatf("tbl_wait_%0d", i), WAIT, vecs[i].exp_wait);
            @(negedge CLK);
            idle_cycles(3);
        end

        // Write 0x6000: E0 edges 3..14, /WAIT releases at 17
        bus_io(16'h6000, 1'b1);
        #1 chk("t1_wait_same_cycle", WAIT, 0);
        run_cycles(20);
        chk("t1_e0_cnt", e0_cnt, 12);
        chk("t1_e0_first", e0_first, 3);
        chk("t1_e1_cnt", e1_cnt, 0);
        chk("t1_wait_rel", wait_rel, 17);
        idle_cycles(2);

        // Read 0x8000 with /IORQ held 10 extra cycles: one strobe only
        bus_io(16'h8000, 1'b0);
        run_cycles(27);
        chk("t2_e1_cnt", e1_cnt, 12);
        chk("t2_e1_first", e1_first, 3);
        chk("t2_e0_cnt", e0_cnt, 0);
        chk("t2_wait_rel", wait_rel, 17);
        chk("t2_busy_held", busy_last, 1);
        idle_cycles(1);
        chk("t2_busy_clear", BUSY, 0);

        // Interrupt-ack and non-LCD I/O held for several cycles
        bus_io(16'h6000, 1'b1); M1 = 1'b0;
        run_cycles(6);
        chk("t3_iack_e0", e0_cnt, 0);
        chk("t3_iack_busy", BUSY, 0);
        bus_io(16'hA000, 1'b1);
        run_cycles(6);
        chk("t3_a000_e", e0_cnt + e1_cnt, 0);
        idle_cycles(1);

        // Reset pulse mid-strobe at edge 8, bus still asserted at release
        bus_io(16'h6000, 1'b1);
        run_cycles(8);
        chk("t4_e0_before_rst", LCD_E0, 1);
        #2 RST = 1'b0;
        #1;
        chk("t4_e0_async", LCD_E0, 0);
        chk("t4_busy_async", BUSY, 0);
        chk("t4_wait_in_rst", WAIT, 1);
        @(negedge CLK);
        @(negedge CLK);
        #2 RST = 1'b1;
        run_cycles(20);
        chk("t4_restart_first", e0_first, S + 1);
        chk("t4_restart_cnt", e0_cnt, 12);
        idle_cycles(2);

        // Abort mid-strobe at edge 6, then a full LCD1 strobe
        bus_io(16'h6000, 1'b1);
        run_cycles(6);
        chk("t5_e0_at6", LCD_E0, 1);
        bus_idle();
        @(negedge CLK);
        chk("t5_e0_at7", LCD_E0, 0);
        chk("t5_state_idle", DBG_STATE, ST_IDLE);
        idle_cycles(1);
        bus_io(16'h8000, 1'b1);
        run_cycles(20);
        chk("t5_e1_cnt", e1_cnt, 12);
        chk("t5_e1_first", e1_first, 3);
        chk("t5_e0_cnt", e0_cnt, 0);
        idle_cycles(2);

        // Back-to-back: LCD0 write, one idle cycle, LCD1 write
        bus_io(16'h6000, 1'b1);
        run_cycles(17);
        chk("t6_first_e0", e0_cnt, 12);
        idle_cycles(1);
        bus_io(16'h8000, 1'b1);
        run_cycles(17);
        chk("t6_second_e1", e1_cnt, 12);
        chk("t6_second_e0", e0_cnt, 0);
        chk("t6_overlap", overlap, 0);
        idle_cycles(2);

        // Randomized traffic, including address changes mid-sequence
        for (int t = 0; t < 60; t++) begin
            int hold;
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0: a = 16'h6000 | 16'($urandom_range(0, 16'h1FFF));
                1: a = 16'h8000 | 16'($urandom_range(0, 16'h1FFF));
                2: a = 16'($urandom);
                default: a = ($urandom_range(0, 1) != 0) ? 16'h4000 : 16'hA000;
            endcase
            ADDR = a;
            M1 = ($urandom_range(0, 5) != 0);
            IOREQ = 1'b0;
            case ($urandom_range(0, 2))
                0: begin R = 1'b0; W = 1'b1; end
                1: begin R = 1'b1; W = 1'b0; end
                default: begin R = 1'b1; W = 1'b1; end
            endcase
            hold = $urandom_range(1, 24);
            for (int c = 0; c < hold; c++) begin
                @(negedge CLK);
                if ($urandom_range(0, 7) == 0) ADDR = 16'($urandom);
            end
            idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(3);
        chk("sb_queue_empty", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
